// File: rtl/gb_ppu_pixel_fifo.sv
// -----------------------------------------------------------------------------
// gb_ppu_pixel_fifo
//
// Pixel FIFO shared by the background/window and object pipelines of the PPU
// draw stage. Whole tile rows arrive from the fetcher in one cycle; the mixer
// sees a show-ahead head pixel and pops one pixel per cycle. With MERGE_EN=1 a
// sprite row can be overlaid onto the queued pixels starting at the head, using
// colour-0 transparency (an already-queued opaque sprite pixel wins).
//
// Pixel entry layout: {color[1:0], obj_palette, bg_priority}.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   flush_i        synchronous clear of all contents
//   push_valid_i   append a full row at the tail
//   push_data_i    row to append, pixel 0 (leftmost) in the low bits
//   push_ready_o   room for a full row (count_o <= DEPTH-ROW)
//   merge_valid_i  overlay a row starting at the head (MERGE_EN=1 only)
//   merge_data_i   object row, pixel 0 in the low bits
//   pop_i          consume the head pixel
//   pop_ack_o      a pop is taken this cycle
//   head_o         show-ahead head pixel, 0 when empty
//   empty_o        no valid entries
//   count_o        number of valid entries
// -----------------------------------------------------------------------------
module gb_ppu_pixel_fifo #(
    parameter int DEPTH    = 16,
    parameter int ROW      = 8,
    parameter int PIX_W    = 4,
    parameter int MERGE_EN = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         push_valid_i,
    input  logic [ROW*PIX_W-1:0]         push_data_i,
    output logic                         push_ready_o,
    input  logic                         merge_valid_i,
    input  logic [ROW*PIX_W-1:0]         merge_data_i,
    input  logic                         pop_i,
    output logic                         pop_ack_o,
    output logic [PIX_W-1:0]             head_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W:0]   DEPTH_W   = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] ROW_C     = CNT_W'(ROW);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - ROW);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] tail_ptr;

    logic merge_fire;
    logic push_fire;
    logic pop_fire;

    // Modular pointer add. base < DEPTH and off <= DEPTH, so one conditional
    // subtraction is enough and DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                   input logic [CNT_W-1:0] off);
        logic [CNT_W:0] sum;
        sum = (CNT_W + 1)'(base) + (CNT_W + 1)'(off);
        if (sum >= DEPTH_W) begin
            sum = sum - DEPTH_W;
        end
        return sum[PTR_W-1:0];
    endfunction

    // Object overlay of one slot. An occupied slot only takes the new pixel
    // when it is transparent and the new one is not; a slot beyond the queued
    // pixels always takes it.
    function automatic logic [PIX_W-1:0] overlay(input logic [PIX_W-1:0] old_pix,
                                                 input logic [PIX_W-1:0] new_pix,
                                                 input logic             occupied);
        logic [PIX_W-1:0] res;
        res = new_pix;
        if (occupied) begin
            if ((old_pix[PIX_W-1 -: 2] == 2'b00) && (new_pix[PIX_W-1 -: 2] != 2'b00)) begin
                res = new_pix;
            end else begin
                res = old_pix;
            end
        end
        return res;
    endfunction

    assign tail_ptr     = wrap_add(head_ptr, count_q);
    assign empty_o      = (count_q == '0);
    assign count_o      = count_q;
    assign push_ready_o = (count_q <= READY_MAX);
    assign head_o       = empty_o ? '0 : mem[head_ptr];

    // Flush outranks merge, merge outranks push/pop.
    assign merge_fire = (MERGE_EN != 0) && merge_valid_i && !flush_i;
    assign push_fire  = push_valid_i && push_ready_o && !flush_i && !merge_fire;
    assign pop_fire   = pop_i && !empty_o && !flush_i && !merge_fire;
    assign pop_ack_o  = pop_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            head_ptr <= '0;
            count_q  <= '0;
        end else if (merge_fire) begin
            for (int i = 0; i < ROW; i++) begin
                mem[wrap_add(head_ptr, CNT_W'(i))] <=
                    overlay(mem[wrap_add(head_ptr, CNT_W'(i))],
                            merge_data_i[i*PIX_W +: PIX_W],
                            CNT_W'(i) < count_q);
            end
            count_q <= (count_q > ROW_C) ? count_q : ROW_C;
        end else begin
            if (push_fire) begin
                for (int i = 0; i < ROW; i++) begin
                    mem[wrap_add(tail_ptr, CNT_W'(i))] <= push_data_i[i*PIX_W +: PIX_W];
                end
            end
            if (pop_fire) begin
                head_ptr <= wrap_add(head_ptr, ONE_C);
            end
            count_q <= count_q + (push_fire ? ROW_C : '0) - (pop_fire ? ONE_C : '0);
        end
    end

endmodule
